execute_divider: RTL and testbench
==================================

// Module: execute_divider
// PURPOSE
//  Multi-cycle DIV/DIVU unit in the Execute stage. Consumes the operands and divide
//  op delivered by the Decode/Execute pipeline register. Holds the pipeline via stall_o
//  while iterating, then returns quotient (LO) and remainder (HI) for one cycle.
//  Radix-2 restoring division on magnitudes, with sign fix-up for signed ops.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//  clk           in   1      rising-edge clock; the block's only clock
//  rst           in   1      synchronous, active-high reset
//  start_i       in   1      divide instruction valid in E (decoded from alucontrolE)
//  signed_i      in   1      1 = DIV (signed), 0 = DIVU; sampled with start_i
//  cancel_i      in   1      flushE/exception annul; aborts any operation in flight
//  dividend_i    in   WIDTH  srcaE (rs value)
//  divisor_i     in   WIDTH  srcbE (rt value)
//  stall_o       out  1      hold IF/ID/E registers while asserted
//  result_vld_o  out  1      one-cycle pulse: quotient_o/remainder_o are valid
//  quotient_o    out  WIDTH  LO result
//  remainder_o   out  WIDTH  HI result
// BEHAVIOUR
//  Reset: state=IDLE; stall_o=0, result_vld_o=0, quotient_o=0, remainder_o=0; counter=0.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: if start_i && !cancel_i in cycle T, latch |dividend|, |divisor|, signed_i
//    and result signs (q_neg = a[W-1]^b[W-1] && signed; r_neg = a[W-1] && signed);
//    clear the partial remainder; counter=0; go to BUSY.
//  - BUSY: one quotient bit per cycle, MSB first; counter increments. After WIDTH
//    cycles (T+1..T+WIDTH), go to DONE.
//  - DONE (cycle T+WIDTH+1): result_vld_o=1; outputs carry sign-corrected results.
//    start_i is ignored here (the same instruction is still in E). Always go to IDLE.
//  stall_o = (IDLE && start_i && !cancel_i) || BUSY; combinational, high T..T+WIDTH.
//    stall_o is low in DONE so the instruction leaves E in that cycle.
//  Outputs are registered. quotient_o/remainder_o hold their last value outside DONE.
//  Sign fix-up: q = q_neg ? -q_mag : q_mag; r = r_neg ? -r_mag : r_mag (mod 2^WIDTH).
//  Divide by zero (divisor 0): full latency still applies, no trap.
//    quotient_o = all ones; remainder_o = dividend_i as sampled.
//    The sign fix-up is skipped for this case.
//  Signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient_o=0x8000_0000, remainder_o=0.
//  cancel_i: in any state, next state = IDLE and result_vld_o stays 0.
//    cancel_i wins over start_i in the same cycle.
//  rst mid-operation: same as reset; no result_vld_o pulse.
//  Back-to-back divides: a start_i in the cycle after DONE is accepted normally.
//    Min spacing between accepts is WIDTH+2 cycles.
// TESTING
//  1. DIVU 100/7, start at T -> stall_o high T..T+32; result_vld_o at T+33; q=14, r=2.
//  2. DIV 0xFFFF_FFF9(-7)/2 -> q=0xFFFF_FFFD(-3), r=0xFFFF_FFFF(-1).
//     DIVU same operands -> q=0x7FFF_FFFC, r=1.
//  3. DIV 0x8000_0000/0xFFFF_FFFF -> q=0x8000_0000, r=0.
//     DIVU 5/0 -> q=0xFFFF_FFFF, r=5, after 33 cycles.
//  4. cancel_i at T+10 -> stall_o low at T+11, no result_vld_o.
//     New start at T+12 completes with result_vld_o at T+45.
//  5. rst at T+20 -> all outputs 0 next cycle, state IDLE.
//     start_i held high through DONE -> exactly one result_vld_o pulse.
//  6. Two consecutive divides (start at T, T+34) -> both results correct.
//     result_vld_o at T+33 and T+67.

Source files
------------

// File: rtl/execute_divider.sv
// execute_divider: multi-cycle radix-2 restoring DIV/DIVU unit that stalls the pipeline while it iterates
module execute_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             stall_o,
  output logic             result_vld_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] aq, b, rem, rem_n, aq_n, a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0] rem_sh, diff;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, dz, accept, last;
  // aq starts as |dividend| and fills with quotient bits from the LSB as dividend bits shift out
  always_comb begin
    accept  = state == IDLE && start_i && !cancel_i;
    last    = state == BUSY && cnt == CW'(WIDTH - 1);
    stall_o = accept || state == BUSY;
    state_n = cancel_i ? IDLE : accept ? BUSY : last ? DONE : state == DONE ? IDLE : state;
    a_abs   = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    b_abs   = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
    rem_sh  = {rem, aq[WIDTH-1]};
    diff    = rem_sh - {1'b0, b};
    rem_n   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    aq_n    = {aq[WIDTH-2:0], ~diff[WIDTH]};
    // a zero divisor yields all-ones quotient and |a| remainder, so only the quotient skips fix-up
    q_fix   = (q_neg && !dz) ? -aq_n : aq_n;
    r_fix   = r_neg ? -rem_n : rem_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      aq           <= '0;
      b            <= '0;
      rem          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz           <= 1'b0;
      result_vld_o <= 1'b0;
      quotient_o   <= '0;
      remainder_o  <= '0;
    end else begin
      state        <= state_n;
      result_vld_o <= last && !cancel_i;
      if (accept) begin
        aq    <= a_abs;
        b     <= b_abs;
        rem   <= '0;
        cnt   <= '0;
        q_neg <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
        r_neg <= signed_i && dividend_i[WIDTH-1];
        dz    <= divisor_i == '0;
      end else if (state == BUSY) begin
        aq  <= aq_n;
        rem <= rem_n;
        cnt <= cnt + 1'b1;
      end
      if (last && !cancel_i) begin
        quotient_o  <= q_fix;
        remainder_o <= r_fix;
      end
    end
  end
endmodule

// File: tb/tb_execute_divider.sv
// tb_execute_divider: directed vectors for execute_divider with hand-computed results and timing
module tb_execute_divider;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, signed_i = 1'b0, cancel_i = 1'b0;
  logic [31:0] dividend_i = '0, divisor_i = '0;
  logic stall_o, result_vld_o;
  logic [31:0] quotient_o, remainder_o;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  execute_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .cancel_i(cancel_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .stall_o(stall_o),
    .result_vld_o(result_vld_o), .quotient_o(quotient_o), .remainder_o(remainder_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  // start at T, expect stall T..T+32 and the result pulse at T+33
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic hold);
    int stalls = 0, pulses = 0;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    #1;
    stalls += int'(stall_o); pulses += int'(result_vld_o);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start_i = hold;
      #1;
      stalls += int'(stall_o); pulses += int'(result_vld_o);
    end
    @(negedge clk);
    start_i = hold;
    #1;
    check({tag, " stall_cycles"}, 32'(stalls), 32'd33);
    check({tag, " early_vld"}, 32'(pulses), 32'd0);
    check({tag, " vld"}, {31'b0, result_vld_o}, 32'd1);
    check({tag, " stall_done"}, {31'b0, stall_o}, 32'd0);
    check({tag, " q"}, quotient_o, eq);
    check({tag, " r"}, remainder_o, er);
    if (hold) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      check({tag, " single_pulse"}, {31'b0, result_vld_o}, 32'd0);
      check({tag, " no_restart"}, {31'b0, stall_o}, 32'd0);
    end
    start_i = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst vld", {31'b0, result_vld_o}, 32'd0);
    check("rst stall", {31'b0, stall_o}, 32'd0);
    check("rst q", quotient_o, 32'd0);
    check("rst r", remainder_o, 32'd0);
    rst = 1'b0;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0);
    // cancel wins over start in IDLE
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
    #1;
    check("cancel_vs_start stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    check("cancel_vs_start idle", {31'b0, stall_o}, 32'd0);
    // cancel at T+10
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd3;
    repeat (9) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    cancel_i = 1'b1;
    #1;
    check("cancel busy_stall", {31'b0, stall_o}, 32'd1);
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    check("cancel stall_low", {31'b0, stall_o}, 32'd0);
    check("cancel no_vld", {31'b0, result_vld_o}, 32'd0);
    check("cancel q_held", quotient_o, 32'hFFFF_FFFF);
    check("cancel r_held", remainder_o, 32'hFFFF_FFF7);
    run_div("after_cancel", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    // reset mid-operation at T+20
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (19) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst vld", {31'b0, result_vld_o}, 32'd0);
    check("midrst stall", {31'b0, stall_o}, 32'd0);
    check("midrst q", quotient_o, 32'd0);
    check("midrst r", remainder_o, 32'd0);
    run_div("hold_start", 1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 1'b1);
    run_div("b2b_first", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_div("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
